// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- multi-cycle control FSM for the 16-bit RISC-V core.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory port using a
// mem_ready handshake. It traps on illegal opcodes and on memory waits that
// exceed TIMEOUT_CYC cycles.
//
// Parameters:
//   ALU_OP_W    width of alu_op (>=4). Bits above [3] are driven 0.
//   TIMEOUT_CYC consecutive un-acked memory cycles before a timeout trap (1..255)
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   opcode/funct3/funct7 instruction fields taken from the IR
//   mem_ready           memory completes the current request this cycle
//   branch_taken        datapath comparator result for the current funct3
//   pc_write/pc_src     PC load strobe; 0 = ALU result, 1 = ALUOut
//   ir_write            latch IR and oldPC
//   mem_req/mem_we      memory request and write qualifier
//   mem_addr_sel        0 = PC, 1 = ALUOut
//   alu_src_a/alu_src_b ALU operand selects; alu_op is the ALU function
//   reg_write/wb_sel    regfile write enable; 00 ALUOut, 01 MDR, 10 oldPC+2
//   illegal/timeout_err sticky trap causes, cleared only by rst
//   state_o             current state (debug)
//
// Optional build macro CTRL_PERF_CNT_EN adds the cycle_cnt and instret
// performance counters.
module multicycle_ctrl #(
  parameter int ALU_OP_W    = 4,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                mem_ready,
  input  logic                branch_taken,
  output logic                pc_write,
  output logic                pc_src,
  output logic                ir_write,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_addr_sel,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic [1:0]          wb_sel,
  output logic                illegal,
  output logic                timeout_err,
  output logic [2:0]          state_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         instret
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // The last allowed wait cycle. If memory is still not ready here, the
  // request is abandoned.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       ill_q, ill_d;
  logic       to_q, to_d;

  logic is_r, is_i, is_ld, is_st, is_br, is_jal, legal;
  logic [3:0] alu4;
  logic       mem_wait;

  // funct7 contributes only bit 5 (the SUB/SRA selector).
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_ld  = (opcode == OP_LD);
  assign is_st  = (opcode == OP_ST);
  assign is_br  = (opcode == OP_BR);
  assign is_jal = (opcode == OP_JAL);
  assign legal  = is_r | is_i | is_ld | is_st | is_br | is_jal;

  always_comb begin
    state_d      = state_q;
    ill_d        = ill_q;
    to_d         = to_q;
    wait_d       = 8'd0;
    mem_wait     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    ir_write     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu4         = 4'b0000;
    reg_write    = 1'b0;
    wb_sel       = 2'b00;

    unique case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b10;              // PC + 2
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_DECODE: begin
        // oldPC + imm: the branch/JAL target is ready in ALUOut by EXEC.
        alu_src_b = 2'b01;
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          ill_d   = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_r) begin
          alu_src_a = 1'b1;
          alu4      = {funct7[5], funct3};
          state_d   = S_WB;
        end else if (is_i) begin
          // Only the shift-right immediate uses funct7[5] (SRAI vs SRLI).
          alu_src_a = 1'b1;
          alu_src_b = 2'b01;
          alu4      = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
          state_d   = S_WB;
        end else if (is_ld || is_st) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b01;
          state_d   = S_MEM;
        end else if (is_br) begin
          alu_src_a = 1'b1;
          alu4      = 4'b1000;          // SUB for the compare
          pc_src    = 1'b1;
          pc_write  = branch_taken;
          state_d   = S_FETCH;
        end else begin                  // JAL: link oldPC+2, jump to ALUOut
          pc_write  = 1'b1;
          pc_src    = 1'b1;
          reg_write = 1'b1;
          wb_sel    = 2'b10;
          state_d   = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_st;
        if (mem_ready) state_d = is_ld ? S_WB : S_FETCH;
        else           mem_wait = 1'b1;
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = is_ld ? 2'b01 : 2'b00;
        state_d   = S_FETCH;
      end
      S_TRAP: ;
      default: state_d = S_FETCH;
    endcase

    // A memory grant takes priority over the timeout. The counter clears
    // by default and counts only consecutive stalled cycles in one state.
    if (mem_wait) begin
      if (wait_q == WAIT_LAST) begin
        state_d = S_TRAP;
        to_d    = 1'b1;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end

    // During reset, no strobe may leak out. This drops any pending request.
    if (rst) begin
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      ir_write     = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'b00;
      alu4         = 4'b0000;
      reg_write    = 1'b0;
      wb_sel       = 2'b00;
    end
  end

  always_comb begin
    alu_op      = '0;
    alu_op[3:0] = alu4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= 8'd0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
    end
  end

  assign illegal     = ill_q;
  assign timeout_err = to_q;
  assign state_o     = state_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cyc_q, ins_q;

  // An instruction retires when control returns to FETCH after execution.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= 32'd0;
      ins_q <= 32'd0;
    end else begin
      if (state_q != S_TRAP) cyc_q <= cyc_q + 32'd1;
      if (state_d == S_FETCH &&
          (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
        ins_q <= ins_q + 32'd1;
    end
  end

  assign cycle_cnt = cyc_q;
  assign instret   = ins_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  localparam int TO = 15;

  logic       clk = 1'b0, rst = 1'b1;
  logic [6:0] opcode = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic       mem_ready = 1'b0, branch_taken = 1'b0;
  logic       pc_write, pc_src, ir_write, mem_req, mem_we, mem_addr_sel, alu_src_a;
  logic [1:0] alu_src_b, wb_sel;
  logic [3:0] alu_op;
  logic       reg_write, illegal, timeout_err;
  logic [2:0] state_o;

  multicycle_ctrl #(.ALU_OP_W(4), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
    .illegal(illegal), .timeout_err(timeout_err), .state_o(state_o));

  always #5 clk = ~clk;

  // Bit positions of each field in the packed observation word.
  localparam int ST = 21, PCW = 20, PCS = 19, IRW = 18, MRQ = 17, MWE = 16,
                 MAS = 15, SA = 14, SB = 12, AOP = 8, RW = 7, WBS = 5,
                 ILL = 4, TOE = 3;

  typedef struct { logic [23:0] v; logic [23:0] m; string tag; } exp_t;
  exp_t q[$];
  int   vectors = 0, miscompares = 0;

  logic [23:0] ev, em;
  logic        exp_ill = 1'b0, exp_to = 1'b0;

  // Mark a field as checked and set its expected value.
  task automatic put(input int lo, input int w, input int val);
    for (int b = 0; b < w; b++) begin
      ev[lo+b] = val[b];
      em[lo+b] = 1'b1;
    end
  endtask

  // Start one expected cycle. Strobes default to 0, and the sticky flags
  // carry the values the model predicts.
  task automatic beg(input int st);
    ev = '0; em = '0;
    put(ST, 3, st);
    put(PCW, 1, 0); put(IRW, 1, 0); put(MRQ, 1, 0); put(RW, 1, 0);
    put(ILL, 1, int'(exp_ill)); put(TOE, 1, int'(exp_to));
  endtask

  task automatic fin(input string tag, input logic rdy, input logic bt);
    mem_ready    = rdy;
    branch_taken = bt;
    q.push_back('{ev, em, tag});
    @(posedge clk); #1;
  endtask

  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      rst = 1'b1;
      ev = '0; em = '0;
      put(PCW, 1, 0); put(IRW, 1, 0); put(MRQ, 1, 0); put(RW, 1, 0);
      fin("reset", 1'($urandom_range(0, 1)), 1'b0);
    end
    rst = 1'b0;
    exp_ill = 1'b0;
    exp_to  = 1'b0;
  endtask

  task automatic trap_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      beg(5);
      fin("trap", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  // Instruction-level reference. fw and mw are the numbers of stalled cycles
  // before memory grants in FETCH and MEM. abort_mem >= 0 asserts reset on
  // that MEM cycle.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic bt,
                           input int fw, input int mw, input int abort_mem,
                           output logic trapped);
    logic is_r, is_i, is_ld, is_st, is_br, is_jal, rdy;
    is_r  = (op == 7'b0110011); is_i   = (op == 7'b0010011);
    is_ld = (op == 7'b0000011); is_st  = (op == 7'b0100011);
    is_br = (op == 7'b1100011); is_jal = (op == 7'b1101111);
    trapped = 1'b0;
    opcode = op; funct3 = f3; funct7 = f7;

    for (int k = 0; ; k++) begin
      rdy = (k >= fw);
      beg(0);
      put(MRQ, 1, 1); put(MWE, 1, 0); put(MAS, 1, 0);
      put(SA, 1, 0); put(SB, 2, 2); put(AOP, 4, 0);
      if (rdy) begin put(IRW, 1, 1); put(PCW, 1, 1); put(PCS, 1, 0); end
      fin("fetch", rdy, 1'b0);
      if (rdy) break;
      if (k + 1 == TO) begin exp_to = 1'b1; trapped = 1'b1; return; end
    end

    beg(1); put(SA, 1, 0); put(SB, 2, 1); put(AOP, 4, 0);
    fin("decode", 1'b0, 1'b0);
    if (!(is_r || is_i || is_ld || is_st || is_br || is_jal)) begin
      exp_ill = 1'b1; trapped = 1'b1; return;
    end

    beg(2);
    if (is_r) begin
      put(SA, 1, 1); put(SB, 2, 0); put(AOP, 4, int'({f7[5], f3}));
    end else if (is_i) begin
      put(SA, 1, 1); put(SB, 2, 1);
      put(AOP, 4, int'({(f3 == 3'b101) ? f7[5] : 1'b0, f3}));
    end else if (is_ld || is_st) begin
      put(SA, 1, 1); put(SB, 2, 1); put(AOP, 4, 0);
    end else if (is_br) begin
      put(SA, 1, 1); put(SB, 2, 0); put(AOP, 4, 8);
      put(PCS, 1, 1); put(PCW, 1, int'(bt));
    end else begin
      put(PCW, 1, 1); put(PCS, 1, 1); put(RW, 1, 1); put(WBS, 2, 2);
    end
    fin("exec", 1'b0, bt);
    if (is_br || is_jal) return;

    if (is_ld || is_st) begin
      for (int k = 0; ; k++) begin
        if (k == abort_mem) begin rst_cycles(2); return; end
        rdy = (k >= mw);
        beg(3); put(MRQ, 1, 1); put(MAS, 1, 1); put(MWE, 1, int'(is_st));
        fin("mem", rdy, 1'b0);
        if (rdy) break;
        if (k + 1 == TO) begin exp_to = 1'b1; trapped = 1'b1; return; end
      end
      if (is_st) return;
    end

    beg(4); put(RW, 1, 1); put(WBS, 2, is_ld ? 1 : 0);
    fin("wb", 1'b0, 1'b0);
  endtask

  // Monitor: compares each observed cycle against the next queued expectation.
  logic [23:0] act;
  exp_t        cur;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      act = {state_o, pc_write, pc_src, ir_write, mem_req, mem_we, mem_addr_sel,
             alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, illegal,
             timeout_err, 3'b000};
      vectors++;
      if ((act & cur.m) !== (cur.v & cur.m)) begin
        miscompares++;
        $display("FAIL %s @%0t got=%h want=%h mask=%h", cur.tag, $time,
                 act & cur.m, cur.v & cur.m, cur.m);
      end
    end
  end

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r < 14)  return r % 4;
    if (r < 17)  return TO - 1;   // grant on the last allowed cycle
    if (r == 17) return TO + 5;   // never granted in time
    return 0;
  endfunction

  logic [6:0] illops [4] = '{7'b0000000, 7'b1111111, 7'b0110111, 7'b0010111};

  initial begin : stim
    logic       tr;
    logic [6:0] op, f7;
    int         cls, guard;
    @(posedge clk); #1;
    rst_cycles(2);

    run_instr(7'b0010011, 3'b000, 7'h00, 1'b0, 0, 0, -1, tr);   // ADDI
    run_instr(7'b0110011, 3'b000, 7'h20, 1'b0, 0, 0, -1, tr);   // SUB
    run_instr(7'b0010011, 3'b101, 7'h20, 1'b0, 0, 0, -1, tr);   // SRAI
    run_instr(7'b0000011, 3'b010, 7'h00, 1'b0, 1, 3, -1, tr);   // load, 3 waits
    run_instr(7'b0100011, 3'b010, 7'h00, 1'b0, 0, 0, -1, tr);   // store
    run_instr(7'b1100011, 3'b000, 7'h00, 1'b1, 0, 0, -1, tr);   // branch taken
    run_instr(7'b1100011, 3'b001, 7'h00, 1'b0, 0, 0, -1, tr);   // not taken
    run_instr(7'b1101111, 3'b000, 7'h00, 1'b0, 0, 0, -1, tr);   // JAL
    run_instr(7'b0010011, 3'b000, 7'h00, 1'b0, TO-1, 0, -1, tr); // late grant

    run_instr(7'b0000000, 3'b000, 7'h00, 1'b0, 0, 0, -1, tr);   // illegal
    trap_cycles(12); rst_cycles(2);
    run_instr(7'b0010011, 3'b000, 7'h00, 1'b0, 100, 0, -1, tr); // fetch timeout
    trap_cycles(10); rst_cycles(2);
    run_instr(7'b0000011, 3'b000, 7'h00, 1'b0, 0, 5, 2, tr);    // rst mid-MEM
    run_instr(7'b0100011, 3'b000, 7'h00, 1'b0, 0, 100, -1, tr); // MEM timeout
    trap_cycles(4); rst_cycles(1);

    for (int n = 0; n < 150; n++) begin
      cls = $urandom_range(0, 6);
      case (cls)
        0: op = 7'b0110011;
        1: op = 7'b0010011;
        2: op = 7'b0000011;
        3: op = 7'b0100011;
        4: op = 7'b1100011;
        5: op = 7'b1101111;
        default: op = illops[$urandom_range(0, 3)];
      endcase
      f7 = 7'($urandom);
      run_instr(op, 3'($urandom), f7, 1'($urandom_range(0, 1)),
                pick_wait(), pick_wait(), -1, tr);
      if (tr) begin trap_cycles(3); rst_cycles(1); end
    end

    guard = 0;
    while (q.size() > 0 && guard < 10) begin @(negedge clk); guard++; end
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
